id_ex_operand_stage: RTL and testbench

- ID/EX pipeline register that sits directly downstream of the register file.
- Takes the combinational rs1/rs2 read data from the register file and resolves data hazards by forwarding from EX, MEM and WB.
- Detects load-use hazards; when one is found it stalls decode and inserts a bubble.
- Presents registered operands to EX with a valid/ready handshake.

---
 rtl/id_ex_operand_stage.sv | 169 ++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand register: forwards EX/MEM/WB results over register-file data,
// stalls decode on load-use hazards, and drives EX with a valid/ready handshake.
// Optional stall counter enabled by defining HAZARD_STAT_EN.
module id_ex_operand_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef HAZARD_STAT_EN
  output logic [31:0]           stall_cnt,
`endif
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [ADDR_WIDTH-1:0] id_rd_addr,
  input  logic                  id_reg_w,
  input  logic                  id_mem_r,
  input  logic [DATA_WIDTH-1:0] rf_rs1_data,
  input  logic [DATA_WIDTH-1:0] rf_rs2_data,
  input  logic [DATA_WIDTH-1:0] ex_result,
  input  logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                  mem_reg_w,
  input  logic                  mem_mem_r,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic [ADDR_WIDTH-1:0] wb_rd_addr,
  input  logic                  wb_reg_w,
  input  logic [DATA_WIDTH-1:0] wb_rd_data,
  input  logic                  flush,
  input  logic                  ex_ready,
  output logic                  ex_valid,
  output logic [DATA_WIDTH-1:0] ex_rs1_data,
  output logic [DATA_WIDTH-1:0] ex_rs2_data,
  output logic [ADDR_WIDTH-1:0] ex_rd_addr,
  output logic                  ex_reg_w,
  output logic                  ex_mem_r
);

  // Handshake: a transfer on either side happens at posedge when valid && ready.
  // ex_* is held while ex_valid && !ex_ready; decode is refused while EX is
  // blocked, a load hazard is pending, or a flush is in progress.

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  hazard;
  } operand_t;

  logic                  ex_valid_q, ex_valid_d;
  logic [DATA_WIDTH-1:0] ex_rs1_data_q, ex_rs1_data_d;
  logic [DATA_WIDTH-1:0] ex_rs2_data_q, ex_rs2_data_d;
  logic [ADDR_WIDTH-1:0] ex_rd_addr_q, ex_rd_addr_d;
  logic                  ex_reg_w_q, ex_reg_w_d;
  logic                  ex_mem_r_q, ex_mem_r_d;

  logic     adv;
  logic     hazard;
  operand_t op1, op2;

  // Only the highest-priority matching producer decides: a younger ALU result
  // masks an older load to the same register.
  function automatic operand_t resolve(
    input logic                  use_s,
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] rf_data,
    input logic                  p_ex_valid,
    input logic                  p_ex_reg_w,
    input logic                  p_ex_mem_r,
    input logic [ADDR_WIDTH-1:0] p_ex_rd,
    input logic [DATA_WIDTH-1:0] p_ex_data
  );
    operand_t r;
    logic     chk;
    r.data   = rf_data;
    r.hazard = 1'b0;
    chk      = use_s && (addr != '0);
    if (addr == '0) begin
      r.data = '0;
    end else if (chk && p_ex_valid && p_ex_reg_w && (p_ex_rd == addr)) begin
      if (p_ex_mem_r) r.hazard = 1'b1;
      else            r.data   = p_ex_data;
    end else if (chk && mem_reg_w && (mem_rd_addr == addr)) begin
      if (mem_mem_r) r.hazard = 1'b1;
      else           r.data   = mem_rd_data;
    end else if (chk && wb_reg_w && (wb_rd_addr == addr)) begin
      r.data = wb_rd_data;
    end
    return r;
  endfunction

  always_comb begin
    op1 = resolve(id_use_rs1, id_rs1_addr, rf_rs1_data, ex_valid_q, ex_reg_w_q,
                  ex_mem_r_q, ex_rd_addr_q, ex_result);
    op2 = resolve(id_use_rs2, id_rs2_addr, rf_rs2_data, ex_valid_q, ex_reg_w_q,
                  ex_mem_r_q, ex_rd_addr_q, ex_result);
    adv      = !ex_valid_q || ex_ready;
    hazard   = op1.hazard || op2.hazard;
    id_ready = adv && !hazard && !flush;
  end

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_rs1_data_d = ex_rs1_data_q;
    ex_rs2_data_d = ex_rs2_data_q;
    ex_rd_addr_d  = ex_rd_addr_q;
    ex_reg_w_d    = ex_reg_w_q;
    ex_mem_r_d    = ex_mem_r_q;
    if (adv) begin
      if (id_valid && id_ready) begin
        ex_valid_d    = 1'b1;
        ex_rs1_data_d = op1.data;
        ex_rs2_data_d = op2.data;
        ex_rd_addr_d  = id_rd_addr;
        ex_reg_w_d    = id_reg_w;
        ex_mem_r_d    = id_mem_r;
      end else begin
        ex_valid_d = 1'b0;
        ex_reg_w_d = 1'b0;
        ex_mem_r_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_rd_addr_q  <= '0;
      ex_reg_w_q    <= 1'b0;
      ex_mem_r_q    <= 1'b0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      ex_rd_addr_q  <= ex_rd_addr_d;
      ex_reg_w_q    <= ex_reg_w_d;
      ex_mem_r_q    <= ex_mem_r_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_rs1_data = ex_rs1_data_q;
  assign ex_rs2_data = ex_rs2_data_q;
  assign ex_rd_addr  = ex_rd_addr_q;
  assign ex_reg_w    = ex_reg_w_q;
  assign ex_mem_r    = ex_mem_r_q;

`ifdef HAZARD_STAT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Counts decode cycles lost to load-use stalls; sticks at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (id_valid && adv && hazard && !flush && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Randomized bench: an in-order architectural register model predicts every
// operand; a small MEM/WB pipeline model feeds the forwarding inputs.
module tb_id_ex_operand_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int EW = 2 * DW + AW + 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          id_valid = 1'b0, id_ready;
  logic [AW-1:0] id_rs1_addr = '0, id_rs2_addr = '0, id_rd_addr = '0;
  logic          id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_reg_w = 1'b0, id_mem_r = 1'b0;
  logic [DW-1:0] rf_rs1_data = '0, rf_rs2_data = '0, ex_result = '0;
  logic [AW-1:0] mem_rd_addr = '0, wb_rd_addr = '0;
  logic          mem_reg_w = 1'b0, mem_mem_r = 1'b0, wb_reg_w = 1'b0;
  logic [DW-1:0] mem_rd_data = '0, wb_rd_data = '0;
  logic          flush = 1'b0, ex_ready = 1'b0;
  logic          ex_valid, ex_reg_w, ex_mem_r;
  logic [DW-1:0] ex_rs1_data, ex_rs2_data;
  logic [AW-1:0] ex_rd_addr;
`ifdef HAZARD_STAT_EN
  logic [31:0]   stall_cnt;
`endif

  id_ex_operand_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
`ifdef HAZARD_STAT_EN
    .stall_cnt(stall_cnt),
`endif
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd_addr(id_rd_addr), .id_reg_w(id_reg_w), .id_mem_r(id_mem_r),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .ex_result(ex_result),
    .mem_rd_addr(mem_rd_addr), .mem_reg_w(mem_reg_w), .mem_mem_r(mem_mem_r),
    .mem_rd_data(mem_rd_data),
    .wb_rd_addr(wb_rd_addr), .wb_reg_w(wb_reg_w), .wb_rd_data(wb_rd_data),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_rd_addr(ex_rd_addr), .ex_reg_w(ex_reg_w), .ex_mem_r(ex_mem_r)
  );

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] load_q[$];
  logic          mon_en = 1'b0;

  // architectural model: regs is the physical file, shadow is program-order state
  logic [DW-1:0] regs[32];
  logic [DW-1:0] shadow[32];
  logic          m_w = 1'b0, m_m = 1'b0, w_w = 1'b0;
  logic [AW-1:0] m_rd = '0, w_rd = '0;
  logic [DW-1:0] m_alu = '0, m_ld = '0, w_data = '0;

  // current decode instruction and per-cycle drive controls
  logic          cur_v, cur_u1, cur_u2, cur_w, cur_m;
  logic [AW-1:0] cur_rs1, cur_rs2, cur_rd;
  logic [DW-1:0] cur_ld;
  logic          drv_rst = 1'b1, drv_flush = 1'b0, drv_exready = 1'b1;
  logic          last_acc = 1'b0;

  function automatic logic [DW-1:0] alu(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return a + {b[15:0], b[31:16]} + 32'h0000_0101;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic new_instr();
    cur_v   = ($urandom_range(0, 3) != 0);
    cur_rs1 = AW'($urandom_range(0, 7));
    cur_rs2 = AW'($urandom_range(0, 7));
    cur_u1  = ($urandom_range(0, 4) != 0);
    cur_u2  = ($urandom_range(0, 4) != 0);
    cur_rd  = AW'($urandom_range(0, 7));
    cur_w   = ($urandom_range(0, 3) != 0);
    cur_m   = cur_w && ($urandom_range(0, 2) == 0);
    cur_ld  = $urandom;
  endtask

  // driver: one clock cycle of stimulus plus the MEM/WB/regfile model
  task automatic do_cycle();
    logic [DW-1:0] op1, op2, res;
    logic          acc_ex;
    @(negedge clk);
    rst         = drv_rst;
    mem_rd_addr = m_rd;  mem_reg_w = m_w;  mem_mem_r = m_m;  mem_rd_data = m_alu;
    wb_rd_addr  = w_rd;  wb_reg_w  = w_w;  wb_rd_data = w_data;
    ex_result   = alu(ex_rs1_data, ex_rs2_data);
    id_valid    = cur_v;
    id_rs1_addr = cur_rs1; id_rs2_addr = cur_rs2;
    id_use_rs1  = cur_u1;  id_use_rs2  = cur_u2;
    id_rd_addr  = cur_rd;  id_reg_w    = cur_w;  id_mem_r = cur_m;
    rf_rs1_data = regs[cur_rs1];
    rf_rs2_data = regs[cur_rs2];
    flush       = drv_flush;
    ex_ready    = drv_exready;
    #1;
    last_acc = 1'b0;
    acc_ex   = 1'b0;
    if (!drv_rst) begin
      if (flush) check("flush_blocks_id", {127'b0, id_ready}, 128'd0);
      if (id_valid && id_ready) begin
        last_acc = 1'b1;
        op1 = (cur_rs1 == '0) ? '0 : (cur_u1 ? shadow[cur_rs1] : regs[cur_rs1]);
        op2 = (cur_rs2 == '0) ? '0 : (cur_u2 ? shadow[cur_rs2] : regs[cur_rs2]);
        res = alu(op1, op2);
        exp_q.push_back({op1, op2, cur_rd, cur_w, cur_m});
        if (cur_m) load_q.push_back(cur_ld);
        if (cur_w && cur_rd != '0) shadow[cur_rd] = cur_m ? cur_ld : res;
      end
      acc_ex = ex_valid && ex_ready;
    end
    if (w_w && w_rd != '0) regs[w_rd] = w_data;
    w_w = m_w;  w_rd = m_rd;  w_data = m_m ? m_ld : m_alu;
    if (acc_ex) begin
      m_w = ex_reg_w;  m_rd = ex_rd_addr;  m_m = ex_mem_r;
      m_alu = alu(ex_rs1_data, ex_rs2_data);
      m_ld = '0;
      if (ex_mem_r && load_q.size() > 0) m_ld = load_q.pop_front();
    end else begin
      m_w = 1'b0;  m_m = 1'b0;  m_rd = '0;  m_alu = '0;  m_ld = '0;
    end
  endtask

  // monitor: pops one expectation per EX handshake and checks hold behaviour
  logic [EW-1:0] prev_out;
  logic          prev_hold = 1'b0;
  initial begin
    logic [EW-1:0] act;
    logic [EW-1:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        act = {ex_rs1_data, ex_rs2_data, ex_rd_addr, ex_reg_w, ex_mem_r};
        if (prev_hold) check("hold_stable", {57'b0, act}, {57'b0, prev_out});
        if (ex_valid && ex_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=%0h expected=none", act);
          end else begin
            exp = exp_q.pop_front();
            check("ex_operands", {57'b0, act}, {57'b0, exp});
          end
        end
        prev_hold = ex_valid && !ex_ready;
        prev_out  = act;
        if (prev_hold) check("id_ready_in_hold", {127'b0, id_ready}, 128'd0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] stall_before;
    stall_before = '0;
    for (int i = 0; i < 32; i++) begin
      regs[i]   = (i == 0) ? '0 : $urandom;
      shadow[i] = regs[i];
    end

    // reset with a valid instruction waiting in decode
    new_instr();
    cur_v = 1'b1;
    drv_rst = 1'b1;  drv_flush = 1'b0;  drv_exready = 1'b1;
    repeat (2) do_cycle();
    @(posedge clk);
    #1;
    check("reset_ex_valid", {127'b0, ex_valid}, 128'd0);
    check("reset_rs1_data", {96'b0, ex_rs1_data}, 128'd0);
    check("reset_rs2_data", {96'b0, ex_rs2_data}, 128'd0);
    check("reset_rd_ctrl", {121'b0, ex_rd_addr, ex_reg_w, ex_mem_r}, 128'd0);
    mon_en  = 1'b1;
    drv_rst = 1'b0;
    do_cycle();
    check("first_capture", {127'b0, last_acc}, 128'd1);
    new_instr();

    // randomized traffic with backpressure and flushes
    for (int k = 0; k < 600; k++) begin
      drv_flush   = ($urandom_range(0, 7) == 0);
      drv_exready = ($urandom_range(0, 3) != 0);
      do_cycle();
      if (last_acc || !cur_v || drv_flush) new_instr();
    end

    // directed load-use: load x3 then a dependent read of x3
    cur_v = 1'b0;  drv_flush = 1'b0;  drv_exready = 1'b1;
    repeat (4) do_cycle();
    cur_v = 1'b1;  cur_rs1 = '0;  cur_rs2 = '0;  cur_u1 = 1'b0;  cur_u2 = 1'b0;
    cur_rd = 5'd3;  cur_w = 1'b1;  cur_m = 1'b1;  cur_ld = 32'hCAFE_0001;
    n = 0;
    do begin
      do_cycle();
      n++;
    end while (!last_acc && n < 20);
    check("load_issue", {127'b0, last_acc}, 128'd1);
`ifdef HAZARD_STAT_EN
    stall_before = stall_cnt;
`endif
    cur_v = 1'b1;  cur_rs1 = 5'd3;  cur_u1 = 1'b1;  cur_rs2 = 5'd1;  cur_u2 = 1'b0;
    cur_rd = 5'd4;  cur_w = 1'b1;  cur_m = 1'b0;
    n = 0;
    do_cycle();
    while (!last_acc && n < 20) begin
      n++;
      do_cycle();
    end
    check("load_use_stalls", 128'(n), 128'd2);
    @(posedge clk);
    #1;
    check("load_use_operand", {96'b0, ex_rs1_data}, {96'b0, 32'hCAFE_0001});
`ifdef HAZARD_STAT_EN
    check("stall_cnt_delta", {96'b0, stall_cnt - stall_before}, 128'd2);
`endif

    // drain and confirm every expected output appeared
    cur_v = 1'b0;
    repeat (6) do_cycle();
    check("drain_queue", 128'(exp_q.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
